// File: rtl/key_schedule_seq.sv
// ---------------------------------------------------------------------------
// key_schedule_seq
//
// Sequential DES key-schedule generator. A PC-1-permuted key (C||D) is
// accepted on start; the ROUNDS round subkeys are then presented one per
// accepted beat on a valid/ready handshake. Encrypt order rotates each
// half left; decrypt order starts from the key itself and rotates right,
// producing the encrypt sequence in reverse.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   start         request a new schedule (sampled only while ready=1)
//   decrypt       0 = encrypt order, 1 = decrypt order (sampled with start)
//   key_in        C = key_in[KEY_W-1:KEY_W/2], D = key_in[KEY_W/2-1:0]
//   ready         idle, start will be accepted
//   subkey_valid  subkey and round are valid
//   subkey_ready  consumer accepts the current subkey
//   subkey        PC-2 of the current C||D register (combinational)
//   round         current round 1..ROUNDS, 0 when idle
//   done          one-cycle pulse after the last subkey is accepted
// ---------------------------------------------------------------------------
module key_schedule_seq #(
    parameter int                KEY_W     = 56,
    parameter int                SUBKEY_W  = 48,
    parameter int                ROUNDS    = 16,
    parameter logic [ROUNDS-1:0] SHIFT_MAP = 16'h8103
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             decrypt,
    input  logic [KEY_W-1:0]                 key_in,
    output logic                             ready,
    output logic                             subkey_valid,
    input  logic                             subkey_ready,
    output logic [SUBKEY_W-1:0]              subkey,
    output logic [$clog2(ROUNDS+1)-1:0]      round,
    output logic                             done
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam int HW = KEY_W / 2;
    localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] ROUNDS_V = RW'(ROUNDS);

    // DES PC-2: 1-based source bit positions, numbered from the MSB of C||D.
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [KEY_W-1:0]    r_cd,    w_cd_nxt;
    logic [RW-1:0]       r_round, w_round_nxt;
    logic                r_dec,   w_dec_nxt;
    logic                r_done,  w_done_nxt;
    logic [1:0]          w_shift;
    logic [1:0]          w_shift1;
    logic [IW-1:0]       w_eidx;
    logic [IW-1:0]       w_didx;
    logic [RW-1:0]       w_ddiff;

    // Circular rotation of each half independently; C never mixes with D.
    function automatic logic [KEY_W-1:0] rot_cd(input logic [KEY_W-1:0] cd,
                                                input logic [1:0]       s,
                                                input logic             right);
        logic [HW-1:0] c;
        logic [HW-1:0] d;
        c = cd[KEY_W-1:HW];
        d = cd[HW-1:0];
        for (int unsigned k = 0; k < 2; k++) begin
            if (k < s) begin
                if (right) begin
                    c = {c[0], c[HW-1:1]};
                    d = {d[0], d[HW-1:1]};
                end else begin
                    c = {c[HW-2:0], c[HW-1]};
                    d = {d[HW-2:0], d[HW-1]};
                end
            end
        end
        return {c, d};
    endfunction

    // Encrypt: next round r+1 uses bit r (the current round value).
    // Decrypt: transition into round r+1 uses encrypt shift of round ROUNDS-r+1.
    assign w_ddiff  = ROUNDS_V - r_round;
    assign w_eidx   = IW'(r_round);
    assign w_didx   = IW'(w_ddiff);
    assign w_shift1 = SHIFT_MAP[0] ? 2'd1 : 2'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cd    <= '0;
            r_round <= '0;
            r_dec   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cd    <= w_cd_nxt;
            r_round <= w_round_nxt;
            r_dec   <= w_dec_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cd_nxt     = r_cd;
        w_round_nxt  = r_round;
        w_dec_nxt    = r_dec;
        w_done_nxt   = 1'b0;
        w_shift      = 2'd2;
        ready        = 1'b0;
        subkey_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_dec_nxt   = decrypt;
                    w_round_nxt = RW'(1);
                    // Decrypt round 1 is the key itself (total encrypt shift wraps to zero).
                    w_cd_nxt    = decrypt ? key_in : rot_cd(key_in, w_shift1, 1'b0);
                end
            end
            S_RUN: begin
                subkey_valid = 1'b1;
                if (subkey_ready) begin
                    if (r_round == ROUNDS_V) begin
                        w_state_nxt = S_IDLE;
                        w_round_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        if (r_dec) begin
                            w_shift = SHIFT_MAP[w_didx] ? 2'd1 : 2'd2;
                        end else begin
                            w_shift = SHIFT_MAP[w_eidx] ? 2'd1 : 2'd2;
                        end
                        w_round_nxt = r_round + RW'(1);
                        w_cd_nxt    = rot_cd(r_cd, w_shift, r_dec);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // PC-2 straight from the registered C||D: no extra pipeline stage.
    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        assign subkey[SUBKEY_W-1-i] = r_cd[KEY_W-PC2_T[i]];
    end

    assign round = r_round;
    assign done  = r_done;

endmodule

// File: tb/tb_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// tb_key_schedule_seq
//
// Self-checking bench for key_schedule_seq. Expected subkeys come from an
// independent model (cumulative shift from the original key, then PC-2)
// and are queued when start is driven; each accepted beat pops and compares.
// ---------------------------------------------------------------------------
module tb_key_schedule_seq;

    localparam int          KEY_W    = 56;
    localparam int          SUBKEY_W = 48;
    localparam int          ROUNDS   = 16;
    localparam logic [15:0] SMAP     = 16'h8103;

    localparam logic [55:0] KAT_KEY  = 56'hF0CCAAF556678F;
    localparam logic [55:0] WRAP_KEY = {28'h8000000, 28'h8000000};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] key_in;
    logic        ready;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [4:0]  round;
    logic        done;

    always #5 clk = ~clk;

    key_schedule_seq #(
        .KEY_W    (KEY_W),
        .SUBKEY_W (SUBKEY_W),
        .ROUNDS   (ROUNDS),
        .SHIFT_MAP(SMAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .decrypt     (decrypt),
        .key_in      (key_in),
        .ready       (ready),
        .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready),
        .subkey      (subkey),
        .round       (round),
        .done        (done)
    );

    typedef struct packed {
        logic [47:0] sk;
        logic [4:0]  rnd;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [47:0] got     [1:16];
    logic [47:0] enc_seq [1:16];

    function automatic logic [47:0] pc2_ref(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    // C||D at round r: key rotated left by the cumulative encrypt shift.
    // Decrypt round r is encrypt round ROUNDS+1-r.
    function automatic logic [55:0] model_cd(input logic [55:0] key, input logic dec, input int r);
        int          er;
        int          tot;
        logic [27:0] c;
        logic [27:0] d;
        er  = dec ? (ROUNDS + 1 - r) : r;
        tot = 0;
        for (int k = 1; k <= er; k++) tot += SMAP[k-1] ? 1 : 2;
        c = key[55:28];
        d = key[27:0];
        for (int k = 0; k < tot; k++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    // Starts one schedule, scores every accepted beat against the queue and
    // returns at the negedge of the done cycle.
    task automatic play_schedule(input logic [55:0] key, input logic dec, input int bp_mode,
                                 input logic glitch, input logic [55:0] cd1_exp, output int beats);
        int          wait_cyc;
        int          budget;
        int          stall_cnt;
        logic        prev_stall;
        logic [47:0] prev_sk;
        logic [4:0]  prev_rnd;
        logic        last;
        exp_t        e;
        wait_cyc = 0;
        while (ready !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wait: ready=%b required 1", ready);
        end
        start   = 1'b1;
        key_in  = key;
        decrypt = dec;
        for (int r = 1; r <= ROUNDS; r++) begin
            e.sk  = pc2_ref(model_cd(key, dec, r));
            e.rnd = 5'(r);
            sb.push_back(e);
        end
        @(negedge clk);
        start   = 1'b0;
        decrypt = ~dec;   // mode must stay latched
        key_in  = ~key;   // key must not be resampled
        n_cmp++;
        if (subkey_valid !== 1'b1 || round !== 5'd1) begin
            n_err++;
            $display("FAIL latency: valid=%b round=%0d required valid=1 round=1", subkey_valid, round);
        end
        n_cmp++;
        if (dut.r_cd !== cd1_exp) begin
            n_err++;
            $display("FAIL cd_round1: cd=%h required %h", dut.r_cd, cd1_exp);
        end
        beats = 0; stall_cnt = 0; prev_stall = 1'b0; last = 1'b0; budget = 0;
        prev_sk = '0; prev_rnd = '0;
        while (!last && budget < 200) begin
            start = 1'b0;
            if (prev_stall) begin
                n_cmp++;
                if (subkey !== prev_sk || round !== prev_rnd) begin
                    n_err++;
                    $display("FAIL stall_hold: subkey=%h round=%0d required %h/%0d", subkey, round, prev_sk, prev_rnd);
                end
            end
            if (bp_mode == 1 && round == 5'd5 && stall_cnt < 3) begin
                subkey_ready = 1'b0;
                stall_cnt++;
            end else if (bp_mode == 1 && round > 5'd5) begin
                subkey_ready = 1'($urandom_range(0, 1));
            end else begin
                subkey_ready = 1'b1;
            end
            if (glitch && round == 5'd7) begin
                start   = 1'b1;
                key_in  = 56'h123456789ABCDE;
            end
            if (subkey_valid === 1'b1 && subkey_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_underflow: beat with round=%0d required none", round);
                    last = 1'b1;
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (subkey !== e.sk || round !== e.rnd) begin
                        n_err++;
                        $display("FAIL beat: subkey=%h round=%0d required %h/%0d", subkey, round, e.sk, e.rnd);
                    end
                    if ((!dec && e.rnd == 5'd16) || (dec && e.rnd == 5'd1)) begin
                        n_cmp++;
                        if (dut.r_cd !== key) begin
                            n_err++;
                            $display("FAIL cd_is_key: cd=%h required %h", dut.r_cd, key);
                        end
                    end
                    got[int'(e.rnd)] = subkey;
                    beats++;
                    if (e.rnd == 5'd16) last = 1'b1;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = subkey_valid;
                prev_sk    = subkey;
                prev_rnd   = round;
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        if (!last) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: beats=%0d required 16", beats);
        end
        n_cmp++;
        if (done !== 1'b1 || ready !== 1'b1 || subkey_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_cycle: done=%b ready=%b valid=%b required 1/1/0", done, ready, subkey_valid);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d entries required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = '0; subkey_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || subkey_valid !== 1'b0 || round !== 5'd0 || done !== 1'b0 || subkey !== 48'h0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b valid=%b round=%0d done=%b subkey=%h required 1/0/0/0/0",
                     ready, subkey_valid, round, done, subkey);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (subkey_valid !== 1'b0 || round !== 5'd0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready_no_effect: valid=%b round=%0d ready=%b required 0/0/1", subkey_valid, round, ready);
        end
    endtask

    task automatic test_encrypt_kat();
        int beats;
        play_schedule(KAT_KEY, 1'b0, 0, 1'b0, model_cd(KAT_KEY, 1'b0, 1), beats);
        n_cmp++;
        if (got[1] !== 48'h1B02EFFC7072 || got[2] !== 48'h79AED9DBC9E5 || got[16] !== 48'hCB3D8B0E17F5) begin
            n_err++;
            $display("FAIL enc_kat: k1=%h k2=%h k16=%h required 1b02effc7072/79aed9dbc9e5/cb3d8b0e17f5",
                     got[1], got[2], got[16]);
        end
        for (int r = 1; r <= 16; r++) enc_seq[r] = got[r];
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse_width: done=%b required 0", done);
        end
    endtask

    task automatic test_decrypt_kat();
        int beats;
        int bad;
        play_schedule(KAT_KEY, 1'b1, 0, 1'b0, KAT_KEY, beats);
        n_cmp++;
        if (got[1] !== 48'hCB3D8B0E17F5 || got[16] !== 48'h1B02EFFC7072) begin
            n_err++;
            $display("FAIL dec_kat: k1=%h k16=%h required cb3d8b0e17f5/1b02effc7072", got[1], got[16]);
        end
        bad = 0;
        for (int r = 1; r <= 16; r++) if (got[r] !== enc_seq[17-r]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL dec_reverse: %0d rounds differ required 0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int beats;
        int bad;
        play_schedule(KAT_KEY, 1'b0, 1, 1'b0, model_cd(KAT_KEY, 1'b0, 1), beats);
        n_cmp++;
        if (beats != 16) begin
            n_err++;
            $display("FAIL bp_beats: %0d required 16", beats);
        end
        bad = 0;
        for (int r = 1; r <= 16; r++) if (got[r] !== enc_seq[r]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_sequence: %0d rounds differ required 0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_rotation_wrap();
        int beats;
        play_schedule(WRAP_KEY, 1'b0, 0, 1'b0, {28'h0000001, 28'h0000001}, beats);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int beats;
        int bad;
        subkey_ready = 1'b1;
        play_schedule(KAT_KEY, 1'b0, 0, 1'b1, model_cd(KAT_KEY, 1'b0, 1), beats);
        bad = 0;
        for (int r = 1; r <= 16; r++) if (got[r] !== enc_seq[r]) bad++;
        n_cmp++;
        if (bad != 0 || beats != 16) begin
            n_err++;
            $display("FAIL busy_start_ignored: %0d rounds differ, beats=%0d required 0/16", bad, beats);
        end
        // Still in the done cycle: this start must be taken immediately.
        play_schedule(WRAP_KEY, 1'b1, 0, 1'b0, WRAP_KEY, beats);
        n_cmp++;
        if (beats != 16) begin
            n_err++;
            $display("FAIL b2b_beats: %0d required 16", beats);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        int beats;
        start = 1'b1; key_in = KAT_KEY; decrypt = 1'b0; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (round !== 5'd9 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (round !== 5'd9) begin
            n_err++;
            $display("FAIL reach_round9: round=%0d required 9", round);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (subkey_valid !== 1'b0 || round !== 5'd0 || done !== 1'b0 || ready !== 1'b1 || subkey !== 48'h0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b round=%0d done=%b ready=%b subkey=%h required 0/0/0/1/0",
                     subkey_valid, round, done, ready, subkey);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || subkey_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_done_after_reset: done=%b valid=%b required 0/0", done, subkey_valid);
        end
        play_schedule(KAT_KEY, 1'b0, 0, 1'b0, model_cd(KAT_KEY, 1'b0, 1), beats);
        n_cmp++;
        if (got[1] !== 48'h1B02EFFC7072) begin
            n_err++;
            $display("FAIL fresh_round1: k1=%h required 1b02effc7072", got[1]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        key_in = '0;
        subkey_ready = 1'b0;
        test_reset();
        test_encrypt_kat();
        test_decrypt_kat();
        test_backpressure();
        test_rotation_wrap();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
